// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
//   state_e      : FSM state encoding (IDLE waits for a start bit, SHIFT assembles a word)
//   DefaultWidth : default word width in bits
//   cnt_width()  : bit-counter width able to hold 0..n
package shift_deser_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_deser_if.sv
// Serial-in / parallel-out bus of the deserializer.
//   s_in, s_en, s_start, msb_first : serial producer side
//   q, q_valid, q_ready             : parallel word handshake
//   overrun                         : pulse when a completed word is dropped
// Modports: slave = deserializer, master = producer/consumer driving it.
interface shift_deser_if #(
  parameter int unsigned N = shift_deser_pkg::DefaultWidth
);
  logic         s_in;
  logic         s_en;
  logic         s_start;
  logic         msb_first;
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         overrun;

  modport slave (
    input  s_in, s_en, s_start, msb_first, q_ready,
    output q, q_valid, overrun
  );

  modport master (
    output s_in, s_en, s_start, msb_first, q_ready,
    input  q, q_valid, overrun
  );
endinterface

// File: rtl/shift_deser_bit_counter.sv
// Bit counter for the deserializer.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : clear the count; with inc also set, the count becomes 1 (restart)
//   inc        : add one
//   count      : bits received so far in the current word (0..N-1 stored)
//   count_done : the next consumed bit is bit N of the word
module bit_counter
  import shift_deser_pkg::*;
#(
  parameter int unsigned N = DefaultWidth,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         count_done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_done = (count_q == W'(N - 1));

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with a one-word output buffer.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : shift_deser_if.slave (serial input, parallel word handshake, overrun)
// A word starts on s_en & s_start and completes on its N-th bit; the finished word
// moves to a separate output buffer so the next word can be shifted in meanwhile.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input logic             clk,
  input logic             reset,
  shift_deser_if.slave    bus
);

  localparam int unsigned W = cnt_width(N);

  state_e       state_q, state_d;
  logic [N-1:0] sr_q, sr_d;
  logic [N-1:0] word_q, word_d;
  logic [N-1:0] base, shifted;
  logic         dir_q, dir_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic         start, take, complete;
  logic         cnt_clr, cnt_inc, count_done;
  logic [W-1:0] count;

  bit_counter #(
    .N (N)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (count),
    .count_done (count_done)
  );

  always_comb begin
    start    = bus.s_en && bus.s_start;
    take     = start || (bus.s_en && (state_q == SHIFT));
    complete = bus.s_en && !bus.s_start && (state_q == SHIFT) && count_done;

    // Direction is sampled only with the start bit and held for the rest of the word.
    dir_d   = start ? bus.msb_first : dir_q;
    // A start bit discards any partial word, so it shifts into an empty register.
    base    = start ? '0 : sr_q;
    shifted = dir_d ? {base[N-2:0], bus.s_in} : {bus.s_in, base[N-1:1]};

    cnt_clr = start || complete;
    cnt_inc = take && !complete;

    state_d = state_q;
    if (start) begin
      state_d = SHIFT;
    end else if (complete) begin
      state_d = IDLE;
    end

    sr_d = sr_q;
    if (complete) begin
      sr_d = '0;
    end else if (take) begin
      sr_d = shifted;
    end

    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (complete) begin
      // The buffer frees up on this edge if it is empty or being consumed now.
      if (!valid_q || bus.q_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.q_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      dir_q     <= 1'b1;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      dir_q     <= dir_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = word_q;
  assign bus.q_valid = valid_q;
  assign bus.overrun = overrun_q;

  count_in_range: assert property (@(posedge clk) disable iff (!reset) count <= W'(N));

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed word scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based word model.
module tb_shift_deser;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_deser_if #(.N(N)) bus ();

  shift_deser #(
    .N (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bits of the current word in a queue and builds the
  // finished word from bit positions directly.
  bit           m_bits[$];
  bit           m_active;
  bit           m_dir;
  logic [N-1:0] m_q;
  bit           m_qv;
  bit           m_ov;

  initial begin
    m_active = 1'b0;
    m_dir    = 1'b1;
    m_q      = '0;
    m_qv     = 1'b0;
    m_ov     = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      if (reset !== 1'b1) begin
        m_bits.delete();
        m_active = 1'b0;
        m_dir    = 1'b1;
        m_q      = '0;
        m_qv     = 1'b0;
        m_ov     = 1'b0;
      end else begin
        automatic bit           done = 1'b0;
        automatic logic [N-1:0] word = '0;
        automatic bit           hs   = m_qv && bus.q_ready;
        if (bus.s_en) begin
          if (bus.s_start) begin
            m_bits.delete();
            m_bits.push_back(bus.s_in);
            m_dir    = bus.msb_first;
            m_active = 1'b1;
          end else if (m_active) begin
            m_bits.push_back(bus.s_in);
          end
        end
        if (m_active && m_bits.size() == N) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (m_dir) word[N-1-i] = m_bits[i];
            else       word[i]     = m_bits[i];
          end
          m_bits.delete();
          m_active = 1'b0;
        end
        m_ov = 1'b0;
        if (done) begin
          if (!m_qv || bus.q_ready) begin
            m_q  = word;
            m_qv = 1'b1;
          end else begin
            m_ov = 1'b1;
          end
        end else if (hs) begin
          m_qv = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison, well after both the DUT and the model have settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        chk("model q_valid", 32'(bus.q_valid), 32'(m_qv));
        chk("model overrun", 32'(bus.overrun), 32'(m_ov));
        chk("model q", 32'(bus.q), 32'(m_q));
      end
    end
  end

  // Sends bits[n-1] first; msb_first is randomised after the start bit to show it is ignored.
  task automatic send_bits(input logic [31:0] bits, input int n, input bit msb,
                           input bit last_rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_en      = 1'b1;
      bus.s_start   = (i == 0);
      bus.s_in      = bits[n-1-i];
      bus.msb_first = (i == 0) ? msb : 1'($urandom_range(0, 1));
      if (last_rdy && i == n - 1) bus.q_ready = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_en    = 1'b0;
    bus.s_start = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.s_in      = 1'b0;
    bus.s_en      = 1'b0;
    bus.s_start   = 1'b0;
    bus.msb_first = 1'b0;
    bus.q_ready   = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    chk("reset q", 32'(bus.q), 32'h0);
    chk("reset q_valid", 32'(bus.q_valid), 32'h0);
    chk("reset overrun", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // MSB-first word 00011111
    bus.q_ready = 1'b1;
    send_bits(32'b00011111, 8, 1'b1, 1'b0);
    idle();
    chk("msb q", 32'(bus.q), 32'h1F);
    chk("msb q_valid", 32'(bus.q_valid), 32'h1);
    idle();
    chk("msb q_valid drop", 32'(bus.q_valid), 32'h0);

    // Same sequence LSB-first
    send_bits(32'b00011111, 8, 1'b0, 1'b0);
    idle();
    chk("lsb q", 32'(bus.q), 32'hF8);
    chk("lsb q_valid", 32'(bus.q_valid), 32'h1);
    idle();
    chk("lsb q_valid drop", 32'(bus.q_valid), 32'h0);

    // Overrun: consumer stalled across two back-to-back words
    bus.q_ready = 1'b0;
    send_bits(32'hA5, 8, 1'b1, 1'b0);
    send_bits(32'h3C, 8, 1'b1, 1'b0);
    idle();
    chk("ovr q kept", 32'(bus.q), 32'hA5);
    chk("ovr q_valid", 32'(bus.q_valid), 32'h1);
    chk("ovr pulse", 32'(bus.overrun), 32'h1);
    idle();
    chk("ovr pulse end", 32'(bus.overrun), 32'h0);
    chk("ovr q still", 32'(bus.q), 32'hA5);
    bus.q_ready = 1'b1;
    idle();
    chk("ovr drain", 32'(bus.q_valid), 32'h0);

    // Completion coinciding with handshake
    bus.q_ready = 1'b0;
    send_bits(32'hA5, 8, 1'b1, 1'b0);
    send_bits(32'h3C, 8, 1'b1, 1'b1);
    idle();
    chk("same-edge q", 32'(bus.q), 32'h3C);
    chk("same-edge q_valid", 32'(bus.q_valid), 32'h1);
    chk("same-edge overrun", 32'(bus.overrun), 32'h0);
    idle();

    // Resync after a 5-bit partial word
    bus.q_ready = 1'b1;
    send_bits(32'b10110, 5, 1'b1, 1'b0);
    send_bits(32'hC3, 8, 1'b1, 1'b0);
    idle();
    chk("resync q", 32'(bus.q), 32'hC3);
    chk("resync q_valid", 32'(bus.q_valid), 32'h1);
    idle();

    // Reset mid-word
    send_bits(32'b1010, 4, 1'b1, 1'b0);
    @(negedge clk);
    bus.s_en    = 1'b0;
    bus.s_start = 1'b0;
    reset       = 1'b0;
    #1;
    chk("mid-reset q", 32'(bus.q), 32'h0);
    chk("mid-reset q_valid", 32'(bus.q_valid), 32'h0);
    chk("mid-reset overrun", 32'(bus.overrun), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_bits(32'h81, 8, 1'b1, 1'b0);
    idle();
    chk("post-reset q", 32'(bus.q), 32'h81);
    chk("post-reset q_valid", 32'(bus.q_valid), 32'h1);

    // Randomized traffic; the model compare covers every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 399) != 0);
      bus.s_en      = ($urandom_range(0, 3) != 0);
      bus.s_start   = ($urandom_range(0, 11) == 0);
      bus.s_in      = 1'($urandom_range(0, 1));
      bus.msb_first = 1'($urandom_range(0, 1));
      bus.q_ready   = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
